// File: rtl/mips_defs.sv
// Shared MIPS encodings and reset constants for the fetch path.
package mips_defs;

  localparam logic [31:0] PC_RESET  = 32'h0000_3000;
  localparam logic [31:0] NOP       = 32'h0000_0000;

  localparam logic [5:0]  OP_SPECIAL = 6'b000000;
  localparam logic [5:0]  OP_REGIMM  = 6'b000001;
  localparam logic [5:0]  OP_J       = 6'b000010;
  localparam logic [5:0]  OP_JAL     = 6'b000011;
  localparam logic [5:0]  OP_BEQ     = 6'b000100;
  localparam logic [4:0]  RT_BGEZ    = 5'b00001;
  localparam logic [5:0]  FUNCT_JR   = 6'b001000;

  typedef enum logic [2:0] {
    CT_SEQ,
    CT_BEQ,
    CT_BGEZ,
    CT_JUMP,
    CT_JR
  } ctrl_e;

  function automatic ctrl_e decode_ctrl(input logic [31:0] instr);
    ctrl_e c;
    c = CT_SEQ;
    if (instr[31:26] == OP_BEQ)
      c = CT_BEQ;
    else if (instr[31:26] == OP_REGIMM && instr[20:16] == RT_BGEZ)
      c = CT_BGEZ;
    else if (instr[31:26] == OP_J || instr[31:26] == OP_JAL)
      c = CT_JUMP;
    else if (instr[31:26] == OP_SPECIAL && instr[5:0] == FUNCT_JR)
      c = CT_JR;
    return c;
  endfunction

endpackage

// File: rtl/fetch_unit_npc_sel.sv
// Next-PC selection from the control instruction sitting in D.
module npc_sel
  import mips_defs::*;
(
  input  logic [31:0] d_instr,
  input  logic [31:0] d_pc,
  input  logic [31:0] f_pc,
  input  logic [31:0] rs_fwd,
  input  logic        beq_true,
  input  logic        bgez_true,
  output logic [31:0] npc,
  output logic        is_jr
);

  ctrl_e       ctrl;
  logic [31:0] br_off;
  logic        br_taken;

  assign ctrl     = decode_ctrl(d_instr);
  assign br_off   = {{14{d_instr[15]}}, d_instr[15:0], 2'b00};
  assign br_taken = (ctrl == CT_BEQ && beq_true) || (ctrl == CT_BGEZ && bgez_true);
  assign is_jr    = (ctrl == CT_JR);

  always_comb begin
    npc = f_pc + 32'd4;
    if (br_taken)
      npc = d_pc + 32'd4 + br_off;
    else if (ctrl == CT_JUMP)
      npc = {d_pc[31:28], d_instr[25:0], 2'b00};
    else if (ctrl == CT_JR)
      npc = rs_fwd;
  end

endmodule

// File: rtl/fetch_unit.sv
// F-stage PC register and IF/ID pipeline register with delay-slot redirect.
module fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int          IM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] imem_rdata,
  input  logic        beq_true,
  input  logic        bgez_true,
  input  logic [31:0] rs_fwd,
  output logic [31:0] imem_addr,
  output logic [31:0] d_instr,
  output logic [31:0] d_pc,
  output logic [31:0] d_pc8,
  output logic        jr_misaligned,
  output logic        f_out_of_range
);
  import mips_defs::NOP;

  // 33-bit limit so a window ending at 2^32 still compares correctly
  localparam logic [32:0] PC_LIMIT = {1'b0, PC_RESET} + 33'(4 * IM_WORDS);

  logic [31:0] f_pc;
  logic [31:0] npc;
  logic        is_jr;

  npc_sel u_npc_sel (
    .d_instr   (d_instr),
    .d_pc      (d_pc),
    .f_pc      (f_pc),
    .rs_fwd    (rs_fwd),
    .beq_true  (beq_true),
    .bgez_true (bgez_true),
    .npc       (npc),
    .is_jr     (is_jr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      f_pc          <= PC_RESET;
      d_instr       <= NOP;
      d_pc          <= PC_RESET;
      jr_misaligned <= 1'b0;
    end else if (!stall) begin
      f_pc    <= npc;
      d_instr <= imem_rdata;
      d_pc    <= f_pc;
      if (is_jr && rs_fwd[1:0] != 2'b00)
        jr_misaligned <= 1'b1;
    end
  end

  assign imem_addr      = f_pc;
  assign d_pc8          = d_pc + 32'd8;
  assign f_out_of_range = (f_pc < PC_RESET) || ({1'b0, f_pc} >= PC_LIMIT);

endmodule
